sa_feed_ctrl: RTL

Sequences one matrix multiply C = A x B on the ARRAY_W x ARRAY_L systolic array. On start it latches a full A matrix and a full B matrix, for example B from the coefficient ROM. It then drives the array's left and top edges with diagonally skewed operands, clears the PE accumulators beforehand, and pulses done once the last PE has finished accumulating. It sits between the operand ROMs and the PE grid.

---
 rtl/sa_pkg.sv | 26 ++
 rtl/sa_skew_mux.sv | 42 ++++
 rtl/sa_feed_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array feed controller.
//   elem_t      : one operand element (default width)
//   state_t     : controller state encoding
//   feed_cycles : number of FEED cycles for a W x L array with inner dim K
package sa_pkg;

  localparam int unsigned SA_DATA_WIDTH = 8;

  typedef logic [SA_DATA_WIDTH-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Last operand enters PE(W-1,L-1) after K + (W-1) + (L-1) edge cycles.
  function automatic int unsigned feed_cycles(input int unsigned w,
                                              input int unsigned l,
                                              input int unsigned k);
    return k + w + l - 2;
  endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// Combinational diagonal-skew selector.
// Given feed step t_i and the latched A/B matrices, produces the operands
// each array edge should see at step t_i:
//   a_edge_o[i] = A[i][t-i] when 0 <= t-i < K, else 0
//   b_edge_o[j] = B[t-j][j] when 0 <= t-j < K, else 0
// Ports:
//   t_i      : feed step index
//   a_mat_i  : latched A, [0:W-1][0:K-1] elements
//   b_mat_i  : latched B, [0:K-1][0:L-1] elements
//   a_edge_o : left-edge operands per PE row
//   b_edge_o : top-edge operands per PE column
module sa_skew_mux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4,
  parameter int unsigned ARRAY_L    = 4,
  parameter int unsigned ARRAY_K    = 4,
  parameter int unsigned TW         = 4
) (
  input  logic [TW-1:0]                                  t_i,
  input  logic [0:ARRAY_W-1][0:ARRAY_K-1][DATA_WIDTH-1:0] a_mat_i,
  input  logic [0:ARRAY_K-1][0:ARRAY_L-1][DATA_WIDTH-1:0] b_mat_i,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              a_edge_o,
  output logic [0:ARRAY_L-1][DATA_WIDTH-1:0]              b_edge_o
);

  // Matching t == row + k avoids computing a possibly negative index.
  always_comb begin
    a_edge_o = '0;
    b_edge_o = '0;
    for (int unsigned i = 0; i < ARRAY_W; i++) begin
      for (int unsigned k = 0; k < ARRAY_K; k++) begin
        if (32'(t_i) == i + k) a_edge_o[i] = a_mat_i[i][k];
      end
    end
    for (int unsigned j = 0; j < ARRAY_L; j++) begin
      for (int unsigned k = 0; k < ARRAY_K; k++) begin
        if (32'(t_i) == j + k) b_edge_o[j] = b_mat_i[k][j];
      end
    end
  end

endmodule

// File: rtl/sa_feed_ctrl.sv
// Systolic-array feed controller: sequences one C = A x B job.
// Latches A/B on start, clears PE accumulators (LOAD), streams skewed
// operands into the array edges (FEED), waits for the last PE (DRAIN),
// then pulses done (DONE). All outputs are registered.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : job request, accepted in IDLE or DONE only
//   a_mat/b_mat : operand matrices, sampled on the accept cycle
//   a_edge      : left-edge operand per PE row
//   b_edge      : top-edge operand per PE column
//   edge_valid  : high during FEED
//   pe_clear    : one-cycle accumulator clear (LOAD)
//   busy        : high LOAD through DONE
//   done        : one-cycle completion pulse
module sa_feed_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
  parameter int unsigned ARRAY_W    = 4,
  parameter int unsigned ARRAY_L    = 4,
  parameter int unsigned ARRAY_K    = 4,
  parameter int unsigned PE_LATENCY = 1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [0:ARRAY_W-1][0:ARRAY_K-1][DATA_WIDTH-1:0] a_mat,
  input  logic [0:ARRAY_K-1][0:ARRAY_L-1][DATA_WIDTH-1:0] b_mat,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              a_edge,
  output logic [0:ARRAY_L-1][DATA_WIDTH-1:0]              b_edge,
  output logic                                            edge_valid,
  output logic                                            pe_clear,
  output logic                                            busy,
  output logic                                            done
);

  localparam int unsigned C  = feed_cycles(ARRAY_W, ARRAY_L, ARRAY_K);
  localparam int unsigned CW = $clog2(C + PE_LATENCY + 1);

  state_t                                          state_q;
  logic [CW-1:0]                                   cnt_q;
  logic [0:ARRAY_W-1][0:ARRAY_K-1][DATA_WIDTH-1:0] a_q;
  logic [0:ARRAY_K-1][0:ARRAY_L-1][DATA_WIDTH-1:0] b_q;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              a_edge_q;
  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]              b_edge_q;
  logic                                            edge_valid_q;
  logic                                            pe_clear_q;
  logic                                            busy_q;
  logic                                            done_q;

  logic [CW-1:0]                                   t_d;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              a_edge_d;
  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]              b_edge_d;

  // Edges are registered, so the mux looks one step ahead of the
  // displayed feed index: step 0 on LOAD, cnt_q+1 during FEED.
  always_comb begin
    t_d = '0;
    if (state_q == FEED) t_d = cnt_q + CW'(1);
  end

  sa_skew_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_W    (ARRAY_W),
    .ARRAY_L    (ARRAY_L),
    .ARRAY_K    (ARRAY_K),
    .TW         (CW)
  ) u_skew (
    .t_i      (t_d),
    .a_mat_i  (a_q),
    .b_mat_i  (b_q),
    .a_edge_o (a_edge_d),
    .b_edge_o (b_edge_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      a_edge_q     <= '0;
      b_edge_q     <= '0;
      edge_valid_q <= 1'b0;
      pe_clear_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      a_edge_q     <= '0;
      b_edge_q     <= '0;
      edge_valid_q <= 1'b0;
      pe_clear_q   <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= a_mat;
            b_q        <= b_mat;
            state_q    <= LOAD;
            pe_clear_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          state_q      <= FEED;
          cnt_q        <= '0;
          a_edge_q     <= a_edge_d;
          b_edge_q     <= b_edge_d;
          edge_valid_q <= 1'b1;
        end
        FEED: begin
          if (32'(cnt_q) + 1 == C) begin
            cnt_q <= '0;
            if (PE_LATENCY == 0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            cnt_q        <= cnt_q + CW'(1);
            a_edge_q     <= a_edge_d;
            b_edge_q     <= b_edge_d;
            edge_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (32'(cnt_q) + 1 == PE_LATENCY) begin
            cnt_q   <= '0;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (start) begin
            a_q        <= a_mat;
            b_q        <= b_mat;
            state_q    <= LOAD;
            pe_clear_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_edge     = a_edge_q;
  assign b_edge     = b_edge_q;
  assign edge_valid = edge_valid_q;
  assign pe_clear   = pe_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
